// File: rtl/special_result_pipe.sv
`default_nettype none
// ============================================================================
// Module      : special_result_pipe
// Description : Special-case result resolver for the HUB floating-point adder.
//               Classifies X and the effective Y (Y with its sign flipped for
//               subtraction) as +-inf / +-0 / +-1 / none, resolves the special
//               result and carries it through a 2-stage elastic valid/ready
//               pipeline. A saturating counter tracks accepted special results.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, op_sub, x, y          - operand side
//               out_valid/out_ready, result, is_special,
//               x_class, y_class                         - result side
//               count_clr, special_count                 - event counter
//               nan (only with SPECIAL_NAN_FLAG_EN)       - opposite-inf flag
// Config      : define SPECIAL_NAN_FLAG_EN to add the registered nan output.
// Revision    : 1.0 - initial release
// ============================================================================
module special_result_pipe #(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [E+M:0]     x,
    input  logic [E+M:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [E+M:0]     result,
    output logic             is_special,
    output logic [2:0]       x_class,
    output logic [2:0]       y_class,
    input  logic             count_clr,
    output logic [CNT_W-1:0] special_count
`ifdef SPECIAL_NAN_FLAG_EN
    ,
    output logic             nan
`endif
);

    localparam int W = E + M + 1;

    localparam logic [2:0] c_cls_none   = 3'd0;
    localparam logic [2:0] c_cls_inf_p  = 3'd1;
    localparam logic [2:0] c_cls_inf_n  = 3'd2;
    localparam logic [2:0] c_cls_zero_p = 3'd3;
    localparam logic [2:0] c_cls_zero_n = 3'd4;
    localparam logic [2:0] c_cls_one_p  = 3'd5;
    localparam logic [2:0] c_cls_one_n  = 3'd6;

    localparam logic [W-1:0] c_pos_inf  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_neg_inf  = {1'b1, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_pos_zero = '0;
    localparam logic [E-1:0] c_exp_one  = {1'b1, {(E-1){1'b0}}};

    // HUB infinity has an all-ones mantissa as well as an all-ones exponent.
    function automatic logic [2:0] classify(input logic [W-1:0] v);
        logic [E-1:0] ex;
        logic [M-1:0] ma;
        logic         sg;
        ex = v[E+M-1:M];
        ma = v[M-1:0];
        sg = v[E+M];
        if ((&ex) && (&ma))
            classify = sg ? c_cls_inf_n : c_cls_inf_p;
        else if ((ex == '0) && (ma == '0))
            classify = sg ? c_cls_zero_n : c_cls_zero_p;
        else if ((ex == c_exp_one) && (ma == '0))
            classify = sg ? c_cls_one_n : c_cls_one_p;
        else
            classify = c_cls_none;
    endfunction

    // ------------------------------------------------------------------
    // Handshake: a stage loads when empty or when its downstream moves on.
    // out_ready reaches in_ready combinationally through w_s2_load.
    // ------------------------------------------------------------------
    logic w_s2_load;
    logic w_s1_load;
    logic w_in_fire;

    logic r_s2_valid;

    assign w_s2_load = !r_s2_valid || out_ready;
    logic r_s1_valid;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_in_fire = in_valid && w_s1_load;
    assign in_ready  = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: operands and classes
    // ------------------------------------------------------------------
    logic [W-1:0] w_y_eff;
    logic [W-1:0] r_s1_x;
    logic [W-1:0] r_s1_y;
    logic [2:0]   r_s1_xc;
    logic [2:0]   r_s1_yc;

    assign w_y_eff = y ^ {op_sub, {(W-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_xc    <= c_cls_none;
            r_s1_yc    <= c_cls_none;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_x  <= x;
                r_s1_y  <= w_y_eff;
                r_s1_xc <= classify(x);
                r_s1_yc <= classify(w_y_eff);
            end
        end
    end

    // ------------------------------------------------------------------
    // Resolution from stage-1 classes; first matching rule wins.
    // ------------------------------------------------------------------
    logic [W-1:0] w_res;
    logic         w_spec;
    logic         w_nan;

    always_comb begin
        w_res  = '0;
        w_spec = 1'b0;
        w_nan  = 1'b0;
        if ((r_s1_xc == c_cls_inf_p && r_s1_yc == c_cls_inf_n) ||
            (r_s1_xc == c_cls_inf_n && r_s1_yc == c_cls_inf_p)) begin
            w_res  = c_pos_inf;
            w_spec = 1'b1;
            w_nan  = 1'b1;
        end else if (r_s1_xc == c_cls_inf_p || r_s1_yc == c_cls_inf_p) begin
            // both +inf, or a single +inf
            w_res  = c_pos_inf;
            w_spec = 1'b1;
        end else if (r_s1_xc == c_cls_inf_n || r_s1_yc == c_cls_inf_n) begin
            w_res  = c_neg_inf;
            w_spec = 1'b1;
        end else if ((r_s1_xc == c_cls_zero_p && r_s1_yc == c_cls_zero_n) ||
                     (r_s1_xc == c_cls_zero_n && r_s1_yc == c_cls_zero_p)) begin
            w_res  = c_pos_zero;
            w_spec = 1'b1;
        end else if (r_s1_xc == c_cls_zero_p || r_s1_xc == c_cls_zero_n) begin
            w_res  = r_s1_y;
            w_spec = 1'b1;
        end else if (r_s1_yc == c_cls_zero_p || r_s1_yc == c_cls_zero_n) begin
            w_res  = r_s1_x;
            w_spec = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: resolved result
    // ------------------------------------------------------------------
    logic [W-1:0] r_s2_res;
    logic         r_s2_spec;
    logic [2:0]   r_s2_xc;
    logic [2:0]   r_s2_yc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_spec  <= 1'b0;
            r_s2_xc    <= c_cls_none;
            r_s2_yc    <= c_cls_none;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res  <= w_res;
                r_s2_spec <= w_spec;
                r_s2_xc   <= r_s1_xc;
                r_s2_yc   <= r_s1_yc;
            end
        end
    end

`ifdef SPECIAL_NAN_FLAG_EN
    logic r_s2_nan;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_s2_nan <= 1'b0;
        else if (w_s2_load && r_s1_valid)
            r_s2_nan <= w_nan;
    end
    assign nan = r_s2_nan;
`else
    logic w_nan_unused;
    assign w_nan_unused = w_nan;
`endif

    // ------------------------------------------------------------------
    // Saturating special-result counter; clear wins over increment.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (count_clr)
            r_count <= '0;
        else if (r_s2_valid && out_ready && r_s2_spec && !(&r_count))
            r_count <= r_count + 1'b1;
    end

    assign out_valid     = r_s2_valid;
    assign result        = r_s2_res;
    assign is_special    = r_s2_spec;
    assign x_class       = r_s2_xc;
    assign y_class       = r_s2_yc;
    assign special_count = r_count;

    // Mark the sibling class code used so every localparam has a reader.
    logic [2:0] w_cls_unused;
    assign w_cls_unused = c_cls_one_p ^ c_cls_one_n;

endmodule
`default_nettype wire

// File: tb/tb_special_result_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_special_result_pipe
// Description : Self-checking bench for special_result_pipe (M=23, E=8,
//               CNT_W=2). Vector table plus stall, counter and reset sequences;
//               expected results travel through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_special_result_pipe;

    localparam int M     = 23;
    localparam int E     = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [31:0]      x;
    logic [31:0]      y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic             is_special;
    logic [2:0]       x_class;
    logic [2:0]       y_class;
    logic             count_clr;
    logic [CNT_W-1:0] special_count;
`ifdef SPECIAL_NAN_FLAG_EN
    logic             nan;
`endif

    special_result_pipe #(.M(M), .E(E), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op_sub        (op_sub),
        .x             (x),
        .y             (y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .is_special    (is_special),
        .x_class       (x_class),
        .y_class       (y_class),
        .count_clr     (count_clr),
        .special_count (special_count)
`ifdef SPECIAL_NAN_FLAG_EN
        ,
        .nan           (nan)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        spec;
        logic [2:0]  xc;
        logic [2:0]  yc;
        logic        nan;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        op;
        exp_t        e;
    } vec_t;

    exp_t   sb[$];
    exp_t   cur_exp;
    int     tests = 0;
    int     fails = 0;
    int     model_cnt = 0;
    vec_t   vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard push/pop and counter model, sampled at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            logic xfer_spec;
            xfer_spec = 1'b0;
            chk("special_count", 64'(special_count), 64'(model_cnt));
            if (in_valid && in_ready)
                sb.push_back(cur_exp);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("is_special", 64'(is_special), 64'(e.spec));
                    chk("x_class", 64'(x_class), 64'(e.xc));
                    chk("y_class", 64'(y_class), 64'(e.yc));
`ifdef SPECIAL_NAN_FLAG_EN
                    chk("nan", 64'(nan), 64'(e.nan));
`endif
                    xfer_spec = e.spec;
                end
            end
            if (count_clr)
                model_cnt = 0;
            else if (xfer_spec && model_cnt < (1 << CNT_W) - 1)
                model_cnt = model_cnt + 1;
        end
    end

    // Present one operand pair; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] xv, input logic [31:0] yv, input logic op, input exp_t e);
        bit acc;
        acc      = 1'b0;
        x        = xv;
        y        = yv;
        op_sub   = op;
        cur_exp  = e;
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("in_ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic s, input logic [2:0] xc,
                                input logic [2:0] yc, input logic n);
        exp_t e;
        e.res = r; e.spec = s; e.xc = xc; e.yc = yc; e.nan = n;
        return e;
    endfunction

    task automatic drain();
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        vecs[0]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, mk(32'h7FFFFFFF, 1, 1, 2, 1)};
        vecs[1]  = '{32'h00000000, 32'h00000000, 1'b1, mk(32'h00000000, 1, 3, 4, 0)};
        vecs[2]  = '{32'h80000000, 32'h00000000, 1'b1, mk(32'h80000000, 1, 4, 4, 0)};
        vecs[3]  = '{32'h40000000, 32'h00000000, 1'b0, mk(32'h40000000, 1, 5, 3, 0)};
        vecs[4]  = '{32'h40000000, 32'h3F800000, 1'b0, mk(32'h00000000, 0, 5, 0, 0)};
        vecs[5]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, mk(32'h7FFFFFFF, 1, 1, 1, 0)};
        vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, mk(32'hFFFFFFFF, 1, 2, 2, 0)};
        vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, mk(32'h7FFFFFFF, 1, 1, 2, 1)};
        vecs[8]  = '{32'h3F800000, 32'hFFFFFFFF, 1'b0, mk(32'hFFFFFFFF, 1, 0, 2, 0)};
        vecs[9]  = '{32'h40000000, 32'h7FFFFFFF, 1'b1, mk(32'hFFFFFFFF, 1, 5, 2, 0)};
        vecs[10] = '{32'h12345678, 32'h80000000, 1'b0, mk(32'h12345678, 1, 0, 4, 0)};
        vecs[11] = '{32'h80000000, 32'hC0000000, 1'b0, mk(32'hC0000000, 1, 4, 6, 0)};
        vecs[12] = '{32'h00000000, 32'h80000000, 1'b0, mk(32'h00000000, 1, 3, 4, 0)};
        vecs[13] = '{32'h3F800000, 32'h40000000, 1'b1, mk(32'h00000000, 0, 0, 6, 0)};
        vecs[14] = '{32'h7F800000, 32'h00000000, 1'b0, mk(32'h7F800000, 1, 0, 3, 0)};
        vecs[15] = '{32'h007FFFFF, 32'h00000000, 1'b1, mk(32'h007FFFFF, 1, 0, 4, 0)};

        rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; x = '0; y = '0;
        out_ready = 1'b1; count_clr = 1'b0; cur_exp = mk(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_is_special", 64'(is_special), 64'(0));
        chk("rst_classes", 64'({x_class, y_class}), 64'(0));
        chk("rst_count", 64'(special_count), 64'(0));
        rst = 1'b0;

        // Vector table, back-to-back with out_ready high.
        for (int i = 0; i < 16; i++) send(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].e);
        drain();

        // Latency: visible exactly two edges after presentation.
        send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, mk(32'h7FFFFFFF, 1, 1, 2, 1));
        chk("latency_not_early", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk("latency_two", 64'(out_valid), 64'(1));
        drain();

        // Four back-to-back inputs against a three-cycle stall.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(32'h00000000, 32'h12345670 + i, 1'b0,
                         mk(32'h12345670 + i, 1, 3, 0, 0));
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready_low", 64'(in_ready), 64'(0));
                chk("stall_out_valid", 64'(out_valid), 64'(1));
                held = result;
                @(negedge clk);
                chk("stall_result_held", 64'(result), 64'(held));
                chk("stall_in_ready_still_low", 64'(in_ready), 64'(0));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Counter: clear, saturate, then clear against a concurrent special transfer.
        count_clr = 1'b1;
        @(posedge clk); #1;
        count_clr = 1'b0;
        chk("count_cleared", 64'(special_count), 64'(0));
        for (int i = 0; i < 5; i++) send(32'h00000000, 32'h40000000, 1'b0, mk(32'h40000000, 1, 3, 5, 0));
        drain();
        @(posedge clk); #1;
        chk("count_saturated", 64'(special_count), 64'(3));
        out_ready = 1'b0;
        send(32'h00000000, 32'h40000000, 1'b0, mk(32'h40000000, 1, 3, 5, 0));
        @(posedge clk); #1;
        chk("clr_setup_valid", 64'(out_valid), 64'(1));
        count_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        count_clr = 1'b0;
        chk("clr_beats_inc", 64'(special_count), 64'(0));
        drain();

        // Reset mid-stall with both stages full.
        for (int i = 0; i < 3; i++) send(32'h00000000, 32'h40000000, 1'b0, mk(32'h40000000, 1, 3, 5, 0));
        drain();
        out_ready = 1'b0;
        send(32'h00000000, 32'h3F800001, 1'b0, mk(32'h3F800001, 1, 3, 0, 0));
        send(32'h00000000, 32'h3F800002, 1'b0, mk(32'h3F800002, 1, 3, 0, 0));
        chk("full_in_ready_low", 64'(in_ready), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_count", 64'(special_count), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        model_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'hFFFFFFFF, 32'h00000000, 1'b0, mk(32'hFFFFFFFF, 1, 2, 3, 0));
        chk("post_rst_not_early", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'(1));
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
